// File: rtl/disp_scan_ctrl.sv
// Four-digit display scan controller: digit multiplexing, source select, blinking and blanking.
// Optional power-on lamp test is built when DISP_LAMP_TEST_EN is defined.
module disp_scan_ctrl #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int BLINK_HZ    = 2,
    parameter int LAMP_FRAMES = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] time_digits,
    input  logic [15:0] alarm_digits,
    input  logic [1:0]  mode,
    input  logic        edit_field,
    input  logic        alarm_ring,
    output logic [1:0]  sel,
    output logic [3:0]  num,
    output logic        blank,
    output logic        dp_enable,
    output logic        dp_clk
);
    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int PW        = $clog2(SCAN_DIV);
    localparam int BW        = $clog2(BLINK_DIV + 1);

    if (SCAN_DIV < 2) begin : g_bad_scan
        $error("disp_scan_ctrl: SCAN_DIV must be at least 2");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("disp_scan_ctrl: BLINK_DIV must be at least 1");
    end
    if (LAMP_FRAMES < 1) begin : g_bad_lamp
        $error("disp_scan_ctrl: LAMP_FRAMES must be at least 1");
    end

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    num_q, num_d;
    logic          blank_q, blank_d;
    logic          dp_en_q, dp_en_d;
    logic [1:0]    mode_s_q, mode_s_d;
    logic [15:0]   time_s_q, time_s_d;
    logic [15:0]   alarm_s_q, alarm_s_d;

    logic        tick;
    logic        wrap;
    logic [1:0]  sel_nx;
    logic [1:0]  mode_eff;
    logic [15:0] src;
    logic [3:0]  nib;
    logic        in_edit;
    logic        blank_run;
    logic        lamp_now;
    logic        lamp_nx;

    assign tick   = (pcnt_q == PW'(SCAN_DIV - 1));
    assign wrap   = tick && (sel_q == 2'd3);
    assign sel_nx = sel_q + 2'd1;

    // At the wrap edge digit 0 must come from the incoming sources, not the stale snapshot.
    assign mode_eff = wrap ? mode : mode_s_q;
    assign src      = wrap ? (mode[0] ? alarm_digits : time_digits)
                           : (mode_s_q[0] ? alarm_s_q : time_s_q);
    assign nib      = src[{sel_nx, 2'b00} +: 4];
    assign in_edit  = edit_field ? sel_nx[1] : ~sel_nx[1];

    assign blank_run = (alarm_ring & blink_phase_q)
                     | (mode_eff[1] & in_edit & blink_phase_q)
                     | (~mode_eff[1] & (sel_nx == 2'd3) & (nib == 4'd0));

`ifdef DISP_LAMP_TEST_EN
    typedef enum logic {ST_LAMP, ST_RUN} state_t;
    localparam int FW = $clog2(LAMP_FRAMES + 1);

    state_t        state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LAMP;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // The first wrap opens frame 1, so the wrap seen with fcnt == LAMP_FRAMES closes the last one.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (state_q == ST_LAMP && wrap) begin
            if (fcnt_q == FW'(LAMP_FRAMES)) state_d = ST_RUN;
            else                            fcnt_d  = fcnt_q + 1'b1;
        end
    end

    assign lamp_now = (state_q == ST_LAMP);
    assign lamp_nx  = (state_d == ST_LAMP);
`else
    assign lamp_now = 1'b0;
    assign lamp_nx  = 1'b0;
`endif

    always_comb begin
        pcnt_d        = tick ? '0 : pcnt_q + 1'b1;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end

        sel_d     = sel_q;
        num_d     = num_q;
        blank_d   = blank_q;
        dp_en_d   = dp_en_q;
        mode_s_d  = mode_s_q;
        time_s_d  = time_s_q;
        alarm_s_d = alarm_s_q;

        if (wrap) begin
            mode_s_d  = mode;
            time_s_d  = time_digits;
            alarm_s_d = alarm_digits;
        end

        if (tick) begin
            sel_d = sel_nx;
            if (lamp_nx) begin
                num_d   = 4'd8;
                blank_d = 1'b0;
                dp_en_d = 1'b1;
            end else begin
                num_d   = nib;
                blank_d = blank_run;
                if (wrap) dp_en_d = ~mode[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q        <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sel_q         <= 2'b11;
            num_q         <= '0;
            blank_q       <= 1'b1;
            dp_en_q       <= 1'b0;
            mode_s_q      <= '0;
            time_s_q      <= '0;
            alarm_s_q     <= '0;
        end else begin
            pcnt_q        <= pcnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            sel_q         <= sel_d;
            num_q         <= num_d;
            blank_q       <= blank_d;
            dp_en_q       <= dp_en_d;
            mode_s_q      <= mode_s_d;
            time_s_q      <= time_s_d;
            alarm_s_q     <= alarm_s_d;
        end
    end

    assign sel       = sel_q;
    assign num       = num_q;
    assign blank     = blank_q;
    assign dp_enable = dp_en_q;
    assign dp_clk    = blink_phase_q & ~lamp_now;

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Four-digit display scan controller for the alarm clock front panel. It time-multiplexes one seven-segment decoder across four anodes by generating the digit select, the digit nibble and the decimal-point controls, and chooses between the time and alarm digit sources. It also applies edit-mode and alarm-ring blinking and leading-zero blanking, and snapshots the sources once per frame so that no frame shows mixed values. It sits between the timekeeping/alarm registers and the segment decoder, and its `blank` output gates the anodes at top level.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `SCAN_HZ`, default 1000: digit-advance rate. `SCAN_DIV = CLK_HZ/SCAN_HZ` and must be ≥ 2.
- `BLINK_HZ`, default 2: blink frequency. `BLINK_DIV = CLK_HZ/(2*BLINK_HZ)` and must be ≥ 1.
- `LAMP_FRAMES`, default 250: lamp-test length in frames. Used only with `DISP_LAMP_TEST_EN`.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `time_digits` in 16: current time nibbles; digit i = `[4i+3:4i]`; digit 3 is leftmost (hours tens).
- `alarm_digits` in 16: alarm time nibbles, same layout as `time_digits`.
- `mode` in 2: 00 show time, 01 show alarm, 10 edit time, 11 edit alarm.
- `edit_field` in 1: 0 selects minutes (digits 1:0); 1 selects hours (digits 3:2).
- `alarm_ring` in 1: 1 flashes the whole display.
- `sel` out 2: active digit index, wired to the decoder select.
- `num` out 4: nibble for the active digit.
- `blank` out 1: 1 suppresses the active anode.
- `dp_enable` out 1: enables the decimal-point blink.
- `dp_clk` out 1: blink phase that drives the decimal point.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps. `tick` is asserted when `pcnt == SCAN_DIV-1`.
- Blink counter is free-running from reset and toggles `blink_phase` every BLINK_DIV cycles. It is independent of the scan.
- On each tick, `sel` advances 0→1→2→3→0.
- A frame wrap is the tick edge where `sel` goes 3→0. At that edge:
  - `mode`, `time_digits` and `alarm_digits` are snapshotted.
  - `num` for digit 0 is taken directly from the incoming (new) source.
- Source selection: `mode[0]` = 0 selects time; `mode[0]` = 1 selects alarm. This uses the snapshotted mode.
- `num` is the selected nibble [4·sel+3:4·sel]. Values above 9 pass through unmodified.
- `blank` is computed at the tick edge and is 1 when any of the following holds:
  - `alarm_ring` = 1 and `blink_phase` = 1;
  - `mode[1]` = 1, the digit lies in the `edit_field` pair, and `blink_phase` = 1;
  - `mode[1]` = 0, sel = 3, and the nibble = 0 (leading zero).
- `edit_field` and `alarm_ring` are sampled live at each tick, not snapshotted.
- `dp_enable` = 1 when the snapshotted mode is 00 or 10. `dp_clk` = `blink_phase`.
- State machine:
  - LAMP: all digits `num`=8, `blank`=0, `dp_enable`=1, `dp_clk`=0.
  - RUN: normal operation as above.
- Reset behaviour:
  - Reset enters LAMP when the macro is defined, otherwise RUN.
  - Reset values: `sel`=2'b11, `num`=0, `blank`=1, `dp_enable`=0, `dp_clk`=0, `pcnt`=0, blink counter=0, `blink_phase`=0, snapshots=0, frame counter=0.
  - Reset asserted mid-frame returns to these values immediately, without waiting for a clock edge.

## Timing
- `sel`, `num` and `blank` change together on the clock edge that ends the tick cycle. They hold for exactly SCAN_DIV cycles.
- The first tick occurs SCAN_DIV cycles after reset release and is always a frame wrap.
- Source latency: a source change becomes visible on the next frame wrap, at most 4·SCAN_DIV cycles later.
- Blank latency: a `blink_phase` change affects `blank` at the next tick edge. `dp_clk` follows `blink_phase` with no extra delay.
- LAMP→RUN happens on the frame wrap that completes frame LAMP_FRAMES. That edge snapshots sources and presents RUN values for digit 0.
- A `mode` change mid-frame has no effect until the next wrap. This covers simultaneous source and mode changes.

## Configuration
- `DISP_LAMP_TEST_EN` defined:
  - After reset, the block holds the LAMP state for LAMP_FRAMES full frames and lights every segment and the decimal point.
  - It then enters RUN.
- `DISP_LAMP_TEST_EN` undefined:
  - The LAMP state and the frame counter are not built.
  - Reset enters RUN directly.
  - `LAMP_FRAMES` is ignored.

## Test plan
Bench parameters: CLK_HZ=1000, SCAN_HZ=250 (SCAN_DIV=4), BLINK_HZ=25 (BLINK_DIV=20), LAMP_FRAMES=2.
1. Macro off, mode 00, `time_digits`=16'h1234, release reset:
   - at the cycle-4 edge, `sel`=0 and `num`=4;
   - the sequence (sel,num) is (0,4),(1,3),(2,2),(3,1), each held 4 cycles;
   - `dp_enable`=1.
2. Change `time_digits` to 16'h5678 while `sel`=1:
   - digits 2 and 3 still show 2 and 1;
   - the next frame shows 8,7,6,5.
3. Mode 00, `time_digits`=16'h0945:
   - `sel`=3 gives `blank`=1;
   - switch to mode 10 with `edit_field`=0: at the next wrap, digit 3 shows `num`=0 with `blank`=0 whenever `blink_phase`=0.
4. Mode 11, `alarm_digits`=16'h0730, `edit_field`=0:
   - digits 0 and 1 have `blank`=1 only at ticks where `blink_phase`=1;
   - digits 2 and 3 are never blanked;
   - `dp_enable`=0.
5. `alarm_ring`=1 in mode 00: every digit has `blank`=1 at ticks where `blink_phase`=1. Then assert `rst_n`=0 mid-frame: outputs immediately return to `sel`=3, `blank`=1, `num`=0.
6. Macro on, `time_digits`=16'h1234:
   - for 8 ticks after reset, `num`=8, `blank`=0, `dp_enable`=1, `dp_clk`=0;
   - at the 9th tick, `sel`=0, `num`=4 and RUN behaviour resumes.
